// File: rtl/bus_arbiter.sv
// bus_arbiter
//
// Decides who owns the motherboard 68000 bus: the local CPU or one of two
// external DMA masters. Index 0 is the Zorro II slot master (A590/GVP and
// similar). Index 1 is the on-card master. The block runs the BR/BG/BGACK
// handshake with the CPU for the requesters. It gives the bus to exactly one
// master at a time and tells the top level when the CPU side must stop
// driving AS_MB_n and the card strobes.
//
// Parameters
//   SYNC_STAGES    : depth of the input synchronizers (>= 2)
//   TIMEOUT_CYCLES : GRANT cycles allowed before giving up on BGACK_n (4..255)
//
// Ports
//   C7M          in   clock, rising edge
//   RESET        in   synchronous, active-high reset
//   BR_n[1:0]    in   bus requests from masters 1:0, active low, async
//   BGACK_n      in   wired-OR grant acknowledge from the masters, async
//   BG_CPU_n     in   bus grant from the CPU, async
//   AS_CPU_n     in   CPU address strobe, async
//   BR_CPU_n     out  bus request to the CPU
//   BGACK_CPU_n  out  acknowledge to the CPU for the whole external tenure
//   BG_n[1:0]    out  one-hot-low grant to masters 1:0
//   DMA_ACTIVE   out  an external master owns the bus
//   CPU_DRIVE_EN out  CPU side may drive AS_MB_n and the card strobes
//   OWNER        out  index of the current or last grantee
//
// Build option
//   ARB_TIMEOUT_EN : when defined, a master that never acknowledges its
//                    grant loses it after TIMEOUT_CYCLES GRANT cycles.
//                    When undefined, GRANT waits for BGACK_n forever.
//
// Handshake
//   A master requests the bus by holding BR_n[i] low. The arbiter forwards
//   the request on BR_CPU_n. It waits until the CPU grants (BG_CPU_n low),
//   the CPU bus cycle has finished (AS_CPU_n high) and no other master holds
//   BGACK_n. Then it drives BG_n[i] low. The master takes the bus by pulling
//   BGACK_n low. From that point the arbiter holds BGACK_CPU_n low and drops
//   BR_CPU_n and BG_n. The tenure ends when BGACK_n goes high again. One
//   RELEASE cycle, with CPU_DRIVE_EN still low, separates the tenure from the
//   CPU getting the bus back.

module bus_arbiter #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic       C7M,
    input  logic       RESET,
    input  logic [1:0] BR_n,
    input  logic       BGACK_n,
    input  logic       BG_CPU_n,
    input  logic       AS_CPU_n,
    output logic       BR_CPU_n,
    output logic       BGACK_CPU_n,
    output logic [1:0] BG_n,
    output logic       DMA_ACTIVE,
    output logic       CPU_DRIVE_EN,
    output logic       OWNER
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        GRANT   = 3'd2,
        OWNED   = 3'd3,
        RELEASE = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizers. Bit order: {AS_CPU_n, BG_CPU_n, BGACK_n, BR_n}.
    // Every stage resets to 1, so all inputs read as inactive.
    // ------------------------------------------------------------------
    logic [4:0] sync_q [SYNC_STAGES];

    always_ff @(posedge C7M) begin
        if (RESET) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= 5'b11111;
            end
        end else begin
            sync_q[0] <= {AS_CPU_n, BG_CPU_n, BGACK_n, BR_n};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    logic [1:0] s_br_n;
    logic       s_bgack_n;
    logic       s_bg_cpu_n;
    logic       s_as_cpu_n;

    assign s_br_n     = sync_q[SYNC_STAGES-1][1:0];
    assign s_bgack_n  = sync_q[SYNC_STAGES-1][2];
    assign s_bg_cpu_n = sync_q[SYNC_STAGES-1][3];
    assign s_as_cpu_n = sync_q[SYNC_STAGES-1][4];

    // ------------------------------------------------------------------
    // State, owner and round-robin history
    // ------------------------------------------------------------------
    state_t state_q, next_state;
    logic   owner_q, next_owner;
    // No grant has been latched since reset, so a tie goes to index 0.
    logic   have_last_q, next_have_last;
    logic   timeout_hit;

    always_ff @(posedge C7M) begin
        if (RESET) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            have_last_q <= 1'b0;
        end else begin
            state_q     <= next_state;
            owner_q     <= next_owner;
            have_last_q <= next_have_last;
        end
    end

`ifdef ARB_TIMEOUT_EN
    // 8-bit saturating counter. It is cleared on entry to GRANT and counts
    // only while the FSM stays in GRANT.
    logic [7:0] to_cnt_q;

    always_ff @(posedge C7M) begin
        if (RESET) begin
            to_cnt_q <= 8'd0;
        end else if (next_state == GRANT && state_q != GRANT) begin
            to_cnt_q <= 8'd0;
        end else if (state_q == GRANT && to_cnt_q != 8'hff) begin
            to_cnt_q <= to_cnt_q + 8'd1;
        end
    end

    assign timeout_hit = (to_cnt_q == 8'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // Round-robin winner, used only when leaving IDLE.
    logic winner;

    always_comb begin
        winner = 1'b0;
        if (s_br_n == 2'b00) begin
            winner = have_last_q ? ~owner_q : 1'b0;
        end else if (!s_br_n[0]) begin
            winner = 1'b0;
        end else begin
            winner = 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        next_state     = state_q;
        next_owner     = owner_q;
        next_have_last = have_last_q;
        case (state_q)
            IDLE: begin
                if (s_br_n != 2'b11) begin
                    next_state     = REQ;
                    next_owner     = winner;
                    next_have_last = 1'b1;
                end
            end
            REQ: begin
                // If the request is withdrawn, that wins over a grant that
                // arrives in the same cycle.
                if (s_br_n[owner_q]) begin
                    next_state = IDLE;
                end else if (!s_bg_cpu_n && s_as_cpu_n && s_bgack_n) begin
                    next_state = GRANT;
                end
            end
            GRANT: begin
                if (!s_bgack_n) begin
                    next_state = OWNED;
                end else if (timeout_hit) begin
                    next_state = RELEASE;
                end
            end
            OWNED: begin
                if (s_bgack_n) begin
                    next_state = RELEASE;
                end
            end
            RELEASE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode. The decode is taken from the next state, so the
    // registered outputs change on the same edge as the state register.
    // ------------------------------------------------------------------
    logic       br_cpu_n_d, bgack_cpu_n_d, dma_active_d, cpu_drive_en_d;
    logic [1:0] bg_n_d;

    always_comb begin
        br_cpu_n_d     = 1'b1;
        bgack_cpu_n_d  = 1'b1;
        bg_n_d         = 2'b11;
        dma_active_d   = 1'b0;
        cpu_drive_en_d = 1'b1;
        case (next_state)
            IDLE: begin
            end
            REQ: begin
                br_cpu_n_d = 1'b0;
            end
            GRANT: begin
                br_cpu_n_d     = 1'b0;
                bg_n_d         = next_owner ? 2'b01 : 2'b10;
                cpu_drive_en_d = 1'b0;
            end
            OWNED: begin
                bgack_cpu_n_d  = 1'b0;
                dma_active_d   = 1'b1;
                cpu_drive_en_d = 1'b0;
            end
            RELEASE: begin
                cpu_drive_en_d = 1'b0;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge C7M) begin
        if (RESET) begin
            BR_CPU_n     <= 1'b1;
            BGACK_CPU_n  <= 1'b1;
            BG_n         <= 2'b11;
            DMA_ACTIVE   <= 1'b0;
            CPU_DRIVE_EN <= 1'b1;
        end else begin
            BR_CPU_n     <= br_cpu_n_d;
            BGACK_CPU_n  <= bgack_cpu_n_d;
            BG_n         <= bg_n_d;
            DMA_ACTIVE   <= dma_active_d;
            CPU_DRIVE_EN <= cpu_drive_en_d;
        end
    end

    assign OWNER = owner_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed testbench for bus_arbiter. Inputs are driven 1 ns after the
// rising edge. Outputs are read at the same point, so each tick() covers
// exactly one active edge.

module tb_bus_arbiter;

    logic       C7M;
    logic       RESET;
    logic [1:0] BR_n;
    logic       BGACK_n;
    logic       BG_CPU_n;
    logic       AS_CPU_n;
    logic       BR_CPU_n;
    logic       BGACK_CPU_n;
    logic [1:0] BG_n;
    logic       DMA_ACTIVE;
    logic       CPU_DRIVE_EN;
    logic       OWNER;

    int checks = 0;
    int errors = 0;

    bus_arbiter #(
        .SYNC_STAGES   (2),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .C7M         (C7M),
        .RESET       (RESET),
        .BR_n        (BR_n),
        .BGACK_n     (BGACK_n),
        .BG_CPU_n    (BG_CPU_n),
        .AS_CPU_n    (AS_CPU_n),
        .BR_CPU_n    (BR_CPU_n),
        .BGACK_CPU_n (BGACK_CPU_n),
        .BG_n        (BG_n),
        .DMA_ACTIVE  (DMA_ACTIVE),
        .CPU_DRIVE_EN(CPU_DRIVE_EN),
        .OWNER       (OWNER)
    );

    // ---------------- clock / reset ----------------
    initial C7M = 1'b0;
    always #5 C7M = ~C7M;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge C7M);
            #1;
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_br_cpu"},    32'(BR_CPU_n),     32'd1);
        check({tag, "_bgack_cpu"}, 32'(BGACK_CPU_n),  32'd1);
        check({tag, "_bg"},        32'(BG_n),         32'd3);
        check({tag, "_dma"},       32'(DMA_ACTIVE),   32'd0);
        check({tag, "_cde"},       32'(CPU_DRIVE_EN), 32'd1);
        check({tag, "_owner"},     32'(OWNER),        32'd0);
    endtask

    // Invariants checked on every falling edge: the grants are one-hot, and
    // a grant and BGACK_CPU_n are never low together.
    always @(negedge C7M) begin
        if (!RESET) begin
            check("bg_exclusive",
                  32'((BG_n == 2'b00) || (BG_n != 2'b11 && !BGACK_CPU_n)), 32'd0);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        RESET    = 1'b1;
        BR_n     = 2'b11;
        BGACK_n  = 1'b1;
        BG_CPU_n = 1'b1;
        AS_CPU_n = 1'b1;
        tick(2);
        RESET = 1'b0;
        check_reset_values("rst");

        // ---- master 0 tenure, step by step ----
        BR_n = 2'b10;
        tick(2);
        check("t1_br_cpu_early", 32'(BR_CPU_n), 32'd1);
        tick(1);
        check("t1_br_cpu_3", 32'(BR_CPU_n), 32'd0);
        check("t1_owner", 32'(OWNER), 32'd0);
        BG_CPU_n = 1'b0;
        tick(2);
        check("t1_bg_early", 32'(BG_n), 32'd3);
        tick(1);
        check("t1_bg_3", 32'(BG_n), 32'd2);
        check("t1_cde_grant", 32'(CPU_DRIVE_EN), 32'd0);
        BGACK_n  = 1'b0;
        BG_CPU_n = 1'b1;
        BR_n     = 2'b11;
        tick(3);
        check("t1_dma", 32'(DMA_ACTIVE), 32'd1);
        check("t1_bgack_cpu", 32'(BGACK_CPU_n), 32'd0);
        check("t1_br_cpu_owned", 32'(BR_CPU_n), 32'd1);
        check("t1_bg_owned", 32'(BG_n), 32'd3);
        BGACK_n = 1'b1;
        tick(2);
        check("t1_dma_hold", 32'(DMA_ACTIVE), 32'd1);
        tick(1);
        check("t1_release_cde", 32'(CPU_DRIVE_EN), 32'd0);
        check("t1_release_dma", 32'(DMA_ACTIVE), 32'd0);
        tick(1);
        check("t1_cde_4", 32'(CPU_DRIVE_EN), 32'd1);

        // ---- tie after master 0: master 1 wins ----
        BR_n = 2'b00;
        tick(3);
        check("t2_br_cpu", 32'(BR_CPU_n), 32'd0);
        check("t2_owner_rr", 32'(OWNER), 32'd1);
        BG_CPU_n = 1'b0;
        tick(3);
        check("t2_bg_m1", 32'(BG_n), 32'd1);
        BGACK_n  = 1'b0;
        BG_CPU_n = 1'b1;
        tick(3);
        check("t2_dma", 32'(DMA_ACTIVE), 32'd1);
        BR_n    = 2'b10;
        BGACK_n = 1'b1;
        tick(3);
        check("t2_release_cde", 32'(CPU_DRIVE_EN), 32'd0);
        tick(1);
        check("t2_idle_cde", 32'(CPU_DRIVE_EN), 32'd1);
        check("t2_idle_br_cpu", 32'(BR_CPU_n), 32'd1);
        tick(1);
        check("t2_next_owner", 32'(OWNER), 32'd0);
        check("t2_next_br_cpu", 32'(BR_CPU_n), 32'd0);

        // ---- grant held off while the CPU cycle is still running ----
        AS_CPU_n = 1'b0;
        BG_CPU_n = 1'b0;
        tick(4);
        check("t3_bg_as_low", 32'(BG_n), 32'd3);
        AS_CPU_n = 1'b1;
        tick(2);
        check("t3_bg_as_sync", 32'(BG_n), 32'd3);
        tick(1);
        check("t3_bg_granted", 32'(BG_n), 32'd2);
        BGACK_n  = 1'b0;
        BG_CPU_n = 1'b1;
        tick(3);
        check("t3_dma", 32'(DMA_ACTIVE), 32'd1);

        // ---- reset in the middle of a tenure, BGACK_n still low ----
        RESET = 1'b1;
        tick(1);
        check_reset_values("mid_rst");
        RESET   = 1'b0;
        BR_n    = 2'b11;
        BGACK_n = 1'b1;
        tick(4);
        check("t4_settle_br_cpu", 32'(BR_CPU_n), 32'd1);
        check("t4_settle_cde", 32'(CPU_DRIVE_EN), 32'd1);

        // ---- request withdrawn while in REQ ----
        BR_n = 2'b01;
        tick(3);
        check("t5_br_cpu", 32'(BR_CPU_n), 32'd0);
        check("t5_owner", 32'(OWNER), 32'd1);
        BR_n = 2'b11;
        tick(1);
        BG_CPU_n = 1'b0;
        tick(1);
        check("t5_br_cpu_hold", 32'(BR_CPU_n), 32'd0);
        tick(1);
        check("t5_br_cpu_drop", 32'(BR_CPU_n), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            check("t5_no_grant", 32'(BG_n), 32'd3);
        end
        BG_CPU_n = 1'b1;
        tick(3);

        // ---- master that never acknowledges its grant ----
        BR_n     = 2'b10;
        BG_CPU_n = 1'b0;
        tick(3);
        check("t6_req", 32'(BR_CPU_n), 32'd0);
        check("t6_bg_req", 32'(BG_n), 32'd3);
        tick(1);
        check("t6_grant", 32'(BG_n), 32'd2);
        BR_n     = 2'b11;
        BG_CPU_n = 1'b1;
`ifdef ARB_TIMEOUT_EN
        tick(7);
        check("t6_grant_last", 32'(BG_n), 32'd2);
        tick(1);
        check("t6_timeout_bg", 32'(BG_n), 32'd3);
        check("t6_timeout_cde", 32'(CPU_DRIVE_EN), 32'd0);
        check("t6_timeout_br_cpu", 32'(BR_CPU_n), 32'd1);
        tick(1);
        check("t6_idle_cde", 32'(CPU_DRIVE_EN), 32'd1);
`else
        begin
            int held;
            held = 0;
            for (int i = 0; i < 1000; i++) begin
                tick(1);
                if (BG_n == 2'b10 && !CPU_DRIVE_EN) held++;
            end
            check("t6_grant_hold", 32'(held), 32'd1000);
        end
        BGACK_n = 1'b0;
        tick(3);
        check("t6_late_dma", 32'(DMA_ACTIVE), 32'd1);
        BGACK_n = 1'b1;
        tick(4);
        check("t6_late_cde", 32'(CPU_DRIVE_EN), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

- Sequences ownership of the motherboard 68000 bus between the local CPU and up to two external DMA masters (index 0: Zorro II slot master such as A590/GVP; index 1: reserved on-card master).
- Runs the BR/BG/BGACK handshake with the CPU on behalf of the requesters.
- Hands the granted bus to exactly one requester and tells the top level when to stop driving AS_MB_n and the card strobes.
- Sits between the CPU-side pins and the autoconfig, fastram and ata decoders, all of which consume DMA_ACTIVE.

## Interface

Parameters:

- SYNC_STAGES, 2: synchronizer depth for the asynchronous inputs BR_n, BGACK_n, BG_CPU_n and AS_CPU_n (minimum 2).
- TIMEOUT_CYCLES, 64: C7M cycles allowed from asserting BG_n to seeing BGACK_n; range 4..255.

Ports:

- C7M  in  1  Sole clock; all logic on the rising edge.
- RESET  in  1  Synchronous, active-high reset.
- BR_n  in  2  Bus requests from masters 1:0, active low, asynchronous.
- BGACK_n  in  1  Wired-OR bus-grant acknowledge from the masters, active low, asynchronous.
- BG_CPU_n  in  1  Bus grant from the CPU, asynchronous.
- AS_CPU_n  in  1  CPU address strobe, asynchronous.
- BR_CPU_n  out  1  Bus request to the CPU.
- BGACK_CPU_n  out  1  Acknowledge to the CPU, held for the whole external tenure.
- BG_n  out  2  One-hot-low grant to masters 1:0.
- DMA_ACTIVE  out  1  An external master owns the bus.
- CPU_DRIVE_EN  out  1  Top level may drive AS_MB_n and the card strobes from the CPU.
- OWNER  out  1  Index of the current or last grantee.

## Operation

- All asynchronous inputs pass through SYNC_STAGES flops; every rule below refers to the synchronized value (s_ prefix).
- Arbitration uses round-robin: the requester not equal to last OWNER wins a tie. First grant after reset goes to index 0.
- The FSM has the following states:
  - IDLE: BR_CPU_n=1, CPU_DRIVE_EN=1. If any s_BR_n is low, latch the winner into OWNER and go to REQ.
  - REQ: BR_CPU_n=0. Wait for s_BG_CPU_n=0, s_AS_CPU_n=1 and s_BGACK_n=1, then go to GRANT. If the latched requester withdraws (s_BR_n[OWNER]=1) before the grant, return to IDLE with BR_CPU_n=1.
  - GRANT: BG_n[OWNER]=0 and CPU_DRIVE_EN=0. Keep BR_CPU_n=0. Clear the timeout counter on entry.
    - On s_BGACK_n=0, go to OWNED.
    - If the counter reaches TIMEOUT_CYCLES-1 (only when ARB_TIMEOUT_EN is defined), go to RELEASE.
  - OWNED: BGACK_CPU_n=0, DMA_ACTIVE=1, BR_CPU_n=1, BG_n=2'b11. Wait for s_BGACK_n=1, then go to RELEASE.
  - RELEASE: exactly one cycle, with every output inactive except that CPU_DRIVE_EN stays 0. Go to IDLE. CPU_DRIVE_EN returns to 1 on entry to IDLE.
- BG_n never has both bits low. BG_n and BGACK_CPU_n are never both low in the same cycle.
- Requests arriving during OWNED or RELEASE are arbitrated only from IDLE. Back-to-back DMA therefore always passes through IDLE for at least one cycle.
- A request on the other index while in REQ or GRANT does not change OWNER.
- Reset mid-tenure (any state) returns to IDLE on the next edge and forces all outputs to reset values regardless of BGACK_n.

## Timing

- Reset values: BR_CPU_n=1, BGACK_CPU_n=1, BG_n=2'b11, DMA_ACTIVE=0, CPU_DRIVE_EN=1, OWNER=0, synchronizers all 1.
- All outputs are registered; they change only on the C7M rising edge.
- Pin-to-state latency is SYNC_STAGES cycles.
  - BR_n falling edge to BR_CPU_n=0: SYNC_STAGES+1 cycles.
  - BG_CPU_n low (with AS high) to BG_n low: SYNC_STAGES+1 cycles.
  - BGACK_n low to DMA_ACTIVE=1: SYNC_STAGES+1 cycles.
  - BGACK_n rising edge to CPU_DRIVE_EN=1: SYNC_STAGES+2 cycles.
- Timeout counter: 8 bits, saturating, counts only in GRANT.

## Configuration

- ARB_TIMEOUT_EN defined: the GRANT timeout is active, and a master that never acknowledges loses the grant after TIMEOUT_CYCLES and the CPU regains the bus.
- ARB_TIMEOUT_EN undefined: the counter logic is omitted and GRANT waits for BGACK_n indefinitely. The TIMEOUT_CYCLES parameter is ignored.

## Test plan

- Reset, then pull BR_n=2'b10 with BG_CPU_n following BR_CPU_n after 3 cycles.
  - Required: BR_CPU_n low 3 cycles after BR_n; BG_n=2'b10 3 cycles after BG_CPU_n; BGACK_n low gives DMA_ACTIVE=1, BGACK_CPU_n=0 and BR_CPU_n=1.
  - On BGACK_n release: CPU_DRIVE_EN=1 exactly 4 cycles later.
- Both BR_n low after a tenure by master 0 -> grant goes to master 1 (OWNER=1); the next tenure goes to master 0.
- BG_CPU_n low while AS_CPU_n is still low -> BG_n stays 2'b11 until AS_CPU_n has been high for 2 synchronized cycles.
- ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=8, master never asserts BGACK_n -> BG_n=2'b11 after 8 GRANT cycles, RELEASE, then IDLE with CPU_DRIVE_EN=1. Undefined: the grant holds for 1000 cycles.
- Requester drops BR_n while in REQ -> BR_CPU_n returns to 1 and BG_n is never asserted.
- RESET pulsed during OWNED -> next edge shows all reset values, even with BGACK_n still low.
